// File: rtl/mc_init_lmr_seq_pkg.sv
// mc_seq_pkg: shared types and constants for the SDRAM init / Load Mode
// Register sequencer.
//   state_t : sequencer states (3-bit)
//   cmd_t   : command bus encodings
//   svc_t   : type of sequence being serviced
//   A10_BIT : address bit that selects all banks for PRECHARGE
package mc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_PRE_W,
    ST_REF,
    ST_REF_W,
    ST_LMR,
    ST_LMR_W,
    ST_ACK
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_PRE = 2'b01,
    CMD_REF = 2'b10,
    CMD_LMR = 2'b11
  } cmd_t;

  typedef enum logic {
    SVC_INIT = 1'b0,
    SVC_LMR  = 1'b1
  } svc_t;

  localparam int unsigned A10_BIT = 10;

  function automatic logic [7:0] cs_onehot(input logic [2:0] idx);
    logic [7:0] one;
    one = 8'd1;
    return one << idx;
  endfunction

endpackage

// File: rtl/mc_init_lmr_seq_if.sv
// mc_cmd_if: valid/ready command channel from the init/LMR sequencer to the
// memory command arbiter.
//   cmd_valid : command request (master -> slave)
//   cmd_ready : command accepted when high with cmd_valid (slave -> master)
//   cmd       : 00 NOP, 01 PRECHARGE-ALL, 10 AUTO-REFRESH, 11 LMR
//   cmd_cs    : one-hot chip select
//   cmd_addr  : address bus value
//   cmd_ba    : bank address
interface mc_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd;
  logic [7:0]  cmd_cs;
  logic [12:0] cmd_addr;
  logic [1:0]  cmd_ba;

  modport master (
    output cmd_valid, cmd, cmd_cs, cmd_addr, cmd_ba,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd, cmd_cs, cmd_addr, cmd_ba,
    output cmd_ready
  );
endinterface

// File: rtl/mc_init_lmr_seq_prio_enc8.sv
// mc_prio_enc8: combinational 8-bit priority encoder, lowest index wins.
//   req   : request vector
//   index : index of the lowest set bit (0 when none)
//   any   : at least one bit of req is set
module mc_prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] index,
  output logic       any
);

  always_comb begin
    index = '0;
    any   = |req;
    // Scan downward so the lowest set bit is the last one written.
    for (int unsigned i = 8; i > 0; i--) begin
      if (req[i-1]) index = 3'(i - 1);
    end
  end

endmodule

// File: rtl/mc_init_lmr_seq.sv
// mc_init_lmr_seq: services per-chip-select init / LMR requests. Init
// requests beat LMR requests, lowest index wins within a class. An init
// sequence is PRECHARGE-ALL, INIT_REF x AUTO-REFRESH, LMR; an LMR sequence is
// PRECHARGE-ALL, LMR. Each sequence ends with a one-cycle ack to the winner.
//   clk, rst  : clock, asynchronous active-high reset
//   init_req  : level init requests, one per cs
//   lmr_req   : level LMR requests, one per cs
//   init_ack  : one-cycle one-hot ack for a completed init
//   lmr_ack   : one-cycle one-hot ack for a completed LMR
//   cs_sel    : cs being serviced (drives the external tms mux)
//   tms_i     : tms register of cs_sel
//   busy      : sequencer is not idle
//   cmd_if    : command channel to the memory command arbiter
module mc_init_lmr_seq
  import mc_seq_pkg::*;
#(
  parameter int unsigned NUM_CS   = 8,
  parameter int unsigned TRP      = 3,
  parameter int unsigned TRFC     = 7,
  parameter int unsigned TMRD     = 2,
  parameter int unsigned INIT_REF = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CS-1:0] init_req,
  input  logic [NUM_CS-1:0] lmr_req,
  output logic [NUM_CS-1:0] init_ack,
  output logic [NUM_CS-1:0] lmr_ack,
  output logic [2:0]        cs_sel,
  input  logic [31:0]       tms_i,
  output logic              busy,
  mc_cmd_if.master          cmd_if
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  ref_q, ref_d;
  logic [2:0]  cs_sel_q, cs_sel_d;
  svc_t        svc_q, svc_d;
  logic [7:0]  cmd_cs_q, cmd_cs_d;

  logic [2:0]  init_idx, lmr_idx;
  logic        init_any, lmr_any;

  logic        valid_c;
  cmd_t        cmd_c;
  logic [12:0] addr_c;
  logic [7:0]  init_ack_c, lmr_ack_c;
  logic        unused_tms;

  assign unused_tms = ^tms_i[31:10];

  mc_prio_enc8 u_init_enc (
    .req   (init_req),
    .index (init_idx),
    .any   (init_any)
  );

  mc_prio_enc8 u_lmr_enc (
    .req   (lmr_req),
    .index (lmr_idx),
    .any   (lmr_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ref_q    <= '0;
      cs_sel_q <= '0;
      svc_q    <= SVC_INIT;
      cmd_cs_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      cs_sel_q <= cs_sel_d;
      svc_q    <= svc_d;
      cmd_cs_q <= cmd_cs_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ref_d      = ref_q;
    cs_sel_d   = cs_sel_q;
    svc_d      = svc_q;
    cmd_cs_d   = cmd_cs_q;
    valid_c    = 1'b0;
    cmd_c      = CMD_NOP;
    addr_c     = '0;
    init_ack_c = '0;
    lmr_ack_c  = '0;

    case (state_q)
      ST_IDLE: begin
        if (init_any) begin
          cs_sel_d = init_idx;
          svc_d    = SVC_INIT;
          cmd_cs_d = cs_onehot(init_idx);
          state_d  = ST_PRE;
        end else if (lmr_any) begin
          cs_sel_d = lmr_idx;
          svc_d    = SVC_LMR;
          cmd_cs_d = cs_onehot(lmr_idx);
          state_d  = ST_PRE;
        end
      end
      ST_PRE: begin
        valid_c         = 1'b1;
        cmd_c           = CMD_PRE;
        addr_c[A10_BIT] = 1'b1;
        if (cmd_if.cmd_ready) begin
          cnt_d   = 4'(TRP);
          state_d = ST_PRE_W;
        end
      end
      // Wait states leave on the cycle the counter shows 1, giving exactly
      // N idle cycles after the accepting edge.
      ST_PRE_W: begin
        if (cnt_q == 4'd1) state_d = (svc_q == SVC_INIT) ? ST_REF : ST_LMR;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_REF: begin
        valid_c = 1'b1;
        cmd_c   = CMD_REF;
        if (cmd_if.cmd_ready) begin
          ref_d   = ref_q + 4'd1;
          cnt_d   = 4'(TRFC);
          state_d = ST_REF_W;
        end
      end
      ST_REF_W: begin
        if (cnt_q == 4'd1) state_d = (ref_q == 4'(INIT_REF)) ? ST_LMR : ST_REF;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_LMR: begin
        valid_c = 1'b1;
        cmd_c   = CMD_LMR;
        addr_c  = {3'b000, tms_i[9:0]};
        if (cmd_if.cmd_ready) begin
          cnt_d   = 4'(TMRD);
          state_d = ST_LMR_W;
        end
      end
      ST_LMR_W: begin
        if (cnt_q == 4'd1) state_d = ST_ACK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACK: begin
        if (svc_q == SVC_INIT) init_ack_c = cmd_cs_q;
        else                   lmr_ack_c  = cmd_cs_q;
        ref_d    = '0;
        cmd_cs_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_if.cmd_valid = valid_c;
  assign cmd_if.cmd       = cmd_c;
  assign cmd_if.cmd_cs    = cmd_cs_q;
  assign cmd_if.cmd_addr  = addr_c;
  assign cmd_if.cmd_ba    = 2'b00;
  assign init_ack         = init_ack_c;
  assign lmr_ack          = lmr_ack_c;
  assign cs_sel           = cs_sel_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mc_init_lmr_seq.sv
// Testbench for mc_init_lmr_seq: scoreboard of expected commands and acks
// built from the request sets, checked by an independent monitor.
module tb_mc_init_lmr_seq;

  localparam int TRP      = 3;
  localparam int TRFC     = 7;
  localparam int TMRD     = 2;
  localparam int INIT_REF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  init_req, lmr_req, init_ack, lmr_ack;
  logic [2:0]  cs_sel;
  logic [31:0] tms_i;
  logic        busy;
  logic [31:0] tms_tab [8];
  int          ready_mode = 0;
  int          checks = 0;
  int          errors = 0;

  mc_cmd_if cmd_if ();

  mc_init_lmr_seq #(
    .NUM_CS   (8),
    .TRP      (TRP),
    .TRFC     (TRFC),
    .TMRD     (TMRD),
    .INIT_REF (INIT_REF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .init_req (init_req),
    .lmr_req  (lmr_req),
    .init_ack (init_ack),
    .lmr_ack  (lmr_ack),
    .cs_sel   (cs_sel),
    .tms_i    (tms_i),
    .busy     (busy),
    .cmd_if   (cmd_if)
  );

  assign tms_i = tms_tab[cs_sel];

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ack;
    logic [1:0]  cmd;
    logic [7:0]  cs;
    logic [12:0] addr;
    logic [7:0]  iack;
    logic [7:0]  lack;
    int          gap;   // idle cycles before this event, -1 = don't care
  } exp_t;

  exp_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit a, input logic [1:0] c, input logic [7:0] cs,
                              input logic [12:0] ad, input logic [7:0] ia,
                              input logic [7:0] la, input int g);
    exp_t e;
    e.is_ack = a; e.cmd = c; e.cs = cs; e.addr = ad;
    e.iack = ia; e.lack = la; e.gap = g;
    return e;
  endfunction

  // Expected command/ack stream for servicing one chip select.
  task automatic push_seq(input int cs, input bit is_init);
    logic [7:0]  oh;
    logic [31:0] t;
    oh = 8'(1 << cs);
    t  = tms_tab[cs];
    expq.push_back(mk(0, 2'b01, oh, 13'h0400, 8'h00, 8'h00, -1));
    if (is_init)
      for (int k = 1; k <= INIT_REF; k++)
        expq.push_back(mk(0, 2'b10, oh, 13'h0000, 8'h00, 8'h00, (k == 1) ? TRP : TRFC));
    expq.push_back(mk(0, 2'b11, oh, {3'b000, t[9:0]}, 8'h00, 8'h00, is_init ? TRFC : TRP));
    expq.push_back(mk(1, 2'b00, oh, 13'h0000, is_init ? oh : 8'h00, is_init ? 8'h00 : oh, TMRD));
  endtask

  // Service order for a request set presented at once: all inits by
  // ascending index, then all LMRs by ascending index.
  task automatic model(input logic [7:0] iv, input logic [7:0] lv);
    for (int i = 0; i < 8; i++) if (iv[i]) push_seq(i, 1'b1);
    for (int i = 0; i < 8; i++) if (lv[i]) push_seq(i, 1'b0);
  endtask

  // Requester: drops its request in the cycle the ack is seen.
  task automatic step();
    @(negedge clk);
    if (!rst) begin
      init_req = init_req & ~init_ack;
      lmr_req  = lmr_req & ~lmr_ack;
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, 32'(cmd_if.cmd_valid), 0);
    chk({tag, "_cmd"},   32'(cmd_if.cmd), 0);
    chk({tag, "_cs"},    32'(cmd_if.cmd_cs), 0);
    chk({tag, "_addr"},  32'(cmd_if.cmd_addr), 0);
    chk({tag, "_ba"},    32'(cmd_if.cmd_ba), 0);
    chk({tag, "_acks"},  {16'h0, init_ack, lmr_ack}, 0);
    chk({tag, "_busy"},  32'(busy), 0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (((init_req | lmr_req) != 0 || expq.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending entries expected 0", name, expq.size());
    end
    chk({name, "_idle_busy"}, 32'(busy), 0);
    chk({name, "_idle_valid"}, 32'(cmd_if.cmd_valid), 0);
    chk({name, "_idle_cmd_cs"}, 32'(cmd_if.cmd_cs), 0);
  endtask

  task automatic run_batch(input string name, input logic [7:0] iv, input logic [7:0] lv);
    model(iv, lv);
    init_req = iv;
    lmr_req  = lv;
    wait_done(name, 20000);
  endtask

  // cmd_ready generator: 0 always ready, 1 random stalls, 2 never ready.
  initial begin
    cmd_if.cmd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       cmd_if.cmd_ready = 1'b1;
        1:       cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
        default: cmd_if.cmd_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops and compares on every accepted command and every ack.
  initial begin
    int          idle = 0;
    int          rise_gap = 0;
    bit          in_cmd = 0;
    bit          stall = 0;
    logic [1:0]  pc;
    logic [7:0]  pcs;
    logic [12:0] pa;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        idle = 0; in_cmd = 0; stall = 0;
        continue;
      end
      if (stall) begin
        chk("stall_valid", 32'(cmd_if.cmd_valid), 1);
        chk("stall_cmd",   32'(cmd_if.cmd), 32'(pc));
        chk("stall_cs",    32'(cmd_if.cmd_cs), 32'(pcs));
        chk("stall_addr",  32'(cmd_if.cmd_addr), 32'(pa));
      end
      if (cmd_if.cmd_valid && !in_cmd) begin
        in_cmd   = 1;
        rise_gap = idle;
      end
      if ((init_ack | lmr_ack) != 0) begin
        chk("ack_expected", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("ack_kind", 32'(e.is_ack), 1);
          chk("init_ack", 32'(init_ack), 32'(e.iack));
          chk("lmr_ack",  32'(lmr_ack), 32'(e.lack));
          chk("ack_gap",  32'(idle), 32'(e.gap));
          chk("ack_cmd_cs", 32'(cmd_if.cmd_cs), 32'(e.cs));
        end
      end
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        chk("cmd_expected", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("cmd_kind", 32'(e.is_ack), 0);
          chk("cmd",      32'(cmd_if.cmd), 32'(e.cmd));
          chk("cmd_cs",   32'(cmd_if.cmd_cs), 32'(e.cs));
          chk("cmd_addr", 32'(cmd_if.cmd_addr), 32'(e.addr));
          chk("cmd_ba",   32'(cmd_if.cmd_ba), 0);
          if (e.gap >= 0) chk("cmd_gap", 32'(rise_gap), 32'(e.gap));
        end
        idle   = 0;
        in_cmd = 0;
      end else if (!cmd_if.cmd_valid) begin
        chk("nop_when_invalid", 32'(cmd_if.cmd), 0);
        idle++;
      end
      stall = cmd_if.cmd_valid && !cmd_if.cmd_ready;
      pc    = cmd_if.cmd;
      pcs   = cmd_if.cmd_cs;
      pa    = cmd_if.cmd_addr;
    end
  end

  initial begin
    int n;
    int refs;
    logic [7:0] iv, lv;

    rst      = 1'b1;
    init_req = '0;
    lmr_req  = '0;
    for (int i = 0; i < 8; i++) tms_tab[i] = $urandom;
    tms_tab[2] = 32'h0000_0223;
    repeat (2) @(posedge clk);
    #2;
    check_quiet("reset");
    chk("reset_cs_sel", 32'(cs_sel), 0);
    #1 rst = 1'b0;

    // Full init of cs2.
    run_batch("init_cs2", 8'h04, 8'h00);
    // Two LMR-only sequences, lowest index first.
    run_batch("lmr_cs0_cs7", 8'h00, 8'h81);
    // Init of cs4 beats the LMR of cs0.
    run_batch("init_before_lmr", 8'h10, 8'h01);
    // Same cs asks for both: init first, then a separate LMR.
    run_batch("both_same_cs", 8'h40, 8'h40);

    // Stalled PRECHARGE: command must hold steady while not accepted.
    ready_mode = 2;
    model(8'h00, 8'h08);
    lmr_req = 8'h08;
    n = 0;
    while (!cmd_if.cmd_valid && n < 20) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("pre_stall_valid", 32'(cmd_if.cmd_valid), 1);
      chk("pre_stall_busy", 32'(busy), 1);
      step();
    end
    ready_mode = 0;
    wait_done("pre_stall", 2000);

    // Reset during REF_W aborts without an ack; sequence restarts.
    model(8'h20, 8'h00);
    init_req = 8'h20;
    refs = 0;
    n = 0;
    while (refs < 2 && n < 200) begin
      step();
      if (cmd_if.cmd_valid && cmd_if.cmd_ready && cmd_if.cmd == 2'b10) refs++;
      n++;
    end
    chk("reached_ref_w", 32'(refs), 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_quiet("mid_reset");
    chk("mid_reset_cs_sel", 32'(cs_sel), 0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("req_still_high", 32'(init_req), 32'h20);
    push_seq(5, 1'b1);
    wait_done("after_reset", 2000);

    // Request dropped in PRE_W is still completed and acked once.
    model(8'h00, 8'h02);
    lmr_req = 8'h02;
    n = 0;
    while (!(cmd_if.cmd_valid && cmd_if.cmd_ready) && n < 20) begin step(); n++; end
    step();
    lmr_req = 8'h00;
    wait_done("dropped_req", 2000);

    // Random request sets with random command back-pressure.
    ready_mode = 1;
    for (int it = 0; it < 12; it++) begin
      iv = 8'($urandom) & 8'($urandom) & 8'($urandom);
      lv = 8'($urandom) & 8'($urandom);
      if ((iv | lv) == 0) lv = 8'(1 << $urandom_range(0, 7));
      for (int i = 0; i < 8; i++) tms_tab[i] = $urandom;
      run_batch("random", iv, lv);
    end
    ready_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
